// File: rtl/double_dabble_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// display modules that consume its output.
//   state_t    : converter FSM states (IDLE=0, SHIFT=1, DONE=2)
//   bcd_digits : number of BCD digits needed to hold 2^w - 1, so every
//                display block sizes its digit bus the same way.
package double_dabble_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // floor(w * log10(2)) + 1, with log10(2) approximated as 0.30103
   function automatic int bcd_digits(input int w);
      return (w * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit greater than 4 so
// that the following left shift carries correctly into the next digit.
//   din  : scratch digit before correction
//   dout : corrected digit (4-bit result, no carry out)
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/double_dabble_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
// clock) with optional two's-complement input and leading-zero blank flags.
// Sits between counter/RTC arithmetic and the display drivers.
//   clk       : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   in_valid  : binary holds a value to convert
//   in_ready  : converter idle, next in_valid is accepted
//   binary    : value to convert, sampled only on the accept edge
//   out_valid : bcd/sign/blank hold a finished result
//   out_ready : consumer takes the result
//   bcd       : packed BCD, digit k at [4k+3:4k]
//   sign      : input was negative (only possible when SIGNED=1)
//   blank     : bit k set when digit k and all higher digits are zero
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// SHIFT | one magnitude bit shifted into the scratch digits per edge
// DONE  | result presented, held until out_ready
module double_dabble_seq
   import double_dabble_seq_pkg::*;
#(
   parameter int WIDTH_I = 8,
   parameter int SIGNED  = 0,
   parameter int DIGITS  = bcd_digits(WIDTH_I)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH_I-1:0]    binary,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign,
   output logic [DIGITS-1:0]     blank
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = (WIDTH_I > 1) ? $clog2(WIDTH_I) : 1;
   localparam logic [CW-1:0]      CNT_INIT  = CW'(WIDTH_I - 1);
   localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
   localparam logic [WIDTH_I-1:0] ONE       = WIDTH_I'(1);
   localparam logic [DIGITS-1:0]  BLANK_RST = ~DIGITS'(1);

   state_t              state;
   logic [WIDTH_I-1:0]  mag;
   logic [SW-1:0]       scratch;
   logic [CW-1:0]       cnt;
   logic                sign_r;
   logic [SW-1:0]       adj;
   logic [SW-1:0]       shifted;
   logic [DIGITS-1:0]   blank_nxt;
   logic                higher_zero;
   logic                neg_in;
   logic                unused_adj_msb;

   always @(posedge clk) begin
      assert (DIGITS >= bcd_digits(WIDTH_I))
         else $error("double_dabble_seq: DIGITS=%0d too small for WIDTH_I=%0d", DIGITS, WIDTH_I);
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
         );
      end
   endgenerate

   // The top scratch bit is always zero after correction because DIGITS
   // is large enough for the full input range, so it simply drops out.
   assign shifted        = {adj[SW-2:0], mag[WIDTH_I-1]};
   assign unused_adj_msb = adj[SW-1];

   assign neg_in   = (SIGNED != 0) && binary[WIDTH_I-1];
   assign in_ready = (state == IDLE);

   always_comb begin
      higher_zero = 1'b1;
      blank_nxt   = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         higher_zero  = higher_zero & (shifted[4*k +: 4] == 4'd0);
         blank_nxt[k] = higher_zero;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         mag       <= '0;
         scratch   <= '0;
         cnt       <= '0;
         sign_r    <= 1'b0;
         out_valid <= 1'b0;
         bcd       <= '0;
         sign      <= 1'b0;
         blank     <= BLANK_RST;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // ~x+1 of the most negative value wraps to 2^(WIDTH_I-1),
                  // which is exactly its unsigned magnitude.
                  mag     <= neg_in ? (~binary + ONE) : binary;
                  sign_r  <= neg_in;
                  scratch <= '0;
                  cnt     <= CNT_INIT;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= shifted;
               mag     <= mag << 1;
               if (cnt == '0) begin
                  bcd       <= shifted;
                  sign      <= sign_r;
                  blank     <= blank_nxt;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_double_dabble_seq.sv
module tb_double_dabble_seq;

   logic        clk = 1'b0;
   logic        resetn;
   logic        chk_en;

   logic        iv   [3];
   logic        ordy [3];
   logic [15:0] bin  [3];
   logic        ir   [3];
   logic        ov   [3];
   logic        sg   [3];
   logic [19:0] bcdw [3];
   logic [4:0]  blkw [3];

   logic [11:0] bcd0, bcd1;
   logic [19:0] bcd2;
   logic [2:0]  blk0, blk1;
   logic [4:0]  blk2;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   localparam int PW [3] = '{8, 8, 16};
   localparam int PS [3] = '{0, 1, 0};
   localparam int PD [3] = '{3, 3, 5};

   always #5 clk = ~clk;

   double_dabble_seq #(.WIDTH_I(8), .SIGNED(0)) u0 (
      .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir[0]),
      .binary(bin[0][7:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .bcd(bcd0), .sign(sg[0]), .blank(blk0));

   double_dabble_seq #(.WIDTH_I(8), .SIGNED(1)) u1 (
      .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir[1]),
      .binary(bin[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .bcd(bcd1), .sign(sg[1]), .blank(blk1));

   double_dabble_seq #(.WIDTH_I(16), .SIGNED(0)) u2 (
      .clk(clk), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir[2]),
      .binary(bin[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .bcd(bcd2), .sign(sg[2]), .blank(blk2));

   assign bcdw[0] = {8'd0, bcd0};
   assign bcdw[1] = {8'd0, bcd1};
   assign bcdw[2] = bcd2;
   assign blkw[0] = {2'd0, blk0};
   assign blkw[1] = {2'd0, blk1};
   assign blkw[2] = blk2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference result {sign, blank[4:0], bcd[19:0]} from decimal arithmetic.
   function automatic logic [25:0] model_out(input int w, input int sgn, input int dg, input logic [15:0] b);
      int unsigned raw, mag, t, p;
      logic        s;
      logic [19:0] d;
      logic [4:0]  bl;
      raw = 32'(b) & ((32'd1 << w) - 32'd1);
      s   = (sgn != 0) && (((raw >> (w - 1)) & 32'd1) != 0);
      mag = s ? ((32'd1 << w) - raw) : raw;
      d   = '0;
      t   = mag;
      for (int k = 0; k < dg; k++) begin
         d[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      bl = '0;
      p  = 1;
      for (int k = 1; k < dg; k++) begin
         p     = p * 10;
         bl[k] = (mag < p);
      end
      return {s, bl, d};
   endfunction

   // Transaction-level model: 0 = idle, 1 = converting, 2 = result held.
   int          m_st  [3];
   int          m_rem [3];
   logic [15:0] m_val [3];
   logic [25:0] m_out [3];

   always @(posedge clk or negedge resetn) begin
      for (int i = 0; i < 3; i++) begin
         if (!resetn) begin
            m_st[i]  <= 0;
            m_rem[i] <= 0;
            m_out[i] <= model_out(PW[i], PS[i], PD[i], 16'd0);
         end else begin
            case (m_st[i])
               0: if (iv[i]) begin
                     m_val[i] <= bin[i];
                     m_rem[i] <= PW[i];
                     m_st[i]  <= 1;
                  end
               1: if (m_rem[i] == 1) begin
                     m_st[i]  <= 2;
                     m_out[i] <= model_out(PW[i], PS[i], PD[i], m_val[i]);
                  end else begin
                     m_rem[i] <= m_rem[i] - 1;
                  end
               default: if (ordy[i]) m_st[i] <= 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d out_valid", i), 32'(ov[i]), 32'(m_st[i] == 2));
            chk($sformatf("u%0d in_ready", i), 32'(ir[i]), 32'(m_st[i] == 0));
            chk($sformatf("u%0d result", i), 32'({sg[i], blkw[i], bcdw[i]}), 32'(m_out[i]));
         end
      end
   end

   // Drives one value, waits for the result, returns it with the latency
   // in edges counted from the accept edge.
   task automatic conv(input int i, input logic [15:0] v, output logic [19:0] b,
                       output logic s, output logic [4:0] bl, output int lat);
      int g;
      bin[i]  = v;
      iv[i]   = 1'b1;
      ordy[i] = 1'b0;
      g = 0;
      while (!ir[i] && g < 50) begin
         @(posedge clk); #1; g++;
      end
      if (g >= 50) chk($sformatf("u%0d accept timeout", i), 32'(g), 32'(0));
      @(posedge clk); #1;
      iv[i] = 1'b0;
      lat = 0;
      while (!ov[i] && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      b  = bcdw[i];
      s  = sg[i];
      bl = blkw[i];
      ordy[i] = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("u%0d out_valid drop", i), 32'(ov[i]), 32'(0));
   endtask

   logic [19:0] rb;
   logic        rs;
   logic [4:0]  rbl;
   int          lat;
   int          rise [3];
   int          nr;
   logic        prev;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      chk_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b1; bin[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      chk_en = 1'b1;

      chk("reset bcd",       32'(bcd0), 32'h000);
      chk("reset blank",     32'(blk0), 32'b110);
      chk("reset out_valid", 32'(ov[0]), 32'd0);
      chk("reset in_ready",  32'(ir[0]), 32'd1);

      conv(0, 16'd255, rb, rs, rbl, lat);
      chk("255 bcd", 32'(rb), 32'h255);
      chk("255 blank", 32'(rbl), 32'b000);
      chk("255 latency", 32'(lat), 32'd8);

      conv(0, 16'd0, rb, rs, rbl, lat);
      chk("zero bcd", 32'(rb), 32'h000);
      chk("zero blank", 32'(rbl), 32'b110);
      chk("zero sign", 32'(rs), 32'd0);
      conv(0, 16'd7, rb, rs, rbl, lat);
      chk("7 bcd", 32'(rb), 32'h007);
      chk("7 blank", 32'(rbl), 32'b110);

      conv(1, 16'h0080, rb, rs, rbl, lat);
      chk("s80 sign", 32'(rs), 32'd1);
      chk("s80 bcd", 32'(rb), 32'h128);
      conv(1, 16'h00FF, rb, rs, rbl, lat);
      chk("sFF sign", 32'(rs), 32'd1);
      chk("sFF bcd", 32'(rb), 32'h001);
      conv(1, 16'h007F, rb, rs, rbl, lat);
      chk("s7F sign", 32'(rs), 32'd0);
      chk("s7F bcd", 32'(rb), 32'h127);
      conv(1, 16'h0000, rb, rs, rbl, lat);
      chk("s00 sign", 32'(rs), 32'd0);

      // Stall in DONE with a new value pending on in_valid.
      bin[0] = 16'd99; iv[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk); #1;
      bin[0] = 16'd150;
      lat = 0;
      while (!ov[0] && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      chk("stall latency", 32'(lat), 32'd8);
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         chk("stall out_valid", 32'(ov[0]), 32'd1);
         chk("stall in_ready", 32'(ir[0]), 32'd0);
         chk("stall bcd", 32'(bcd0), 32'h099);
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("release in_ready", 32'(ir[0]), 32'd1);
      chk("release out_valid", 32'(ov[0]), 32'd0);
      chk("release bcd held", 32'(bcd0), 32'h099);
      @(posedge clk); #1;
      iv[0]  = 1'b0;
      bin[0] = 16'd3;
      lat = 0;
      while (!ov[0] && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      chk("queued bcd", 32'(bcd0), 32'h150);
      @(posedge clk); #1;

      // Reset on the third SHIFT edge drops the conversion.
      bin[0] = 16'd200; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      chk("mid reset out_valid", 32'(ov[0]), 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("post reset in_ready", 32'(ir[0]), 32'd1);
      chk("post reset out_valid", 32'(ov[0]), 32'd0);
      nr = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (ov[0]) nr++;
      end
      chk("no partial pulse", 32'(nr), 32'd0);
      conv(0, 16'd42, rb, rs, rbl, lat);
      chk("42 bcd", 32'(rb), 32'h042);

      conv(2, 16'd65535, rb, rs, rbl, lat);
      chk("65535 bcd", 32'(rb), 32'h65535);
      chk("65535 latency", 32'(lat), 32'd16);
      chk("65535 blank", 32'(rbl), 32'b00000);
      conv(2, 16'd100, rb, rs, rbl, lat);
      chk("100 bcd", 32'(rb), 32'h00100);
      chk("100 blank", 32'(rbl), 32'b11000);

      bin[2] = 16'd12345; iv[2] = 1'b1; ordy[2] = 1'b1;
      nr = 0; prev = 1'b0;
      for (int c = 0; c < 100 && nr < 3; c++) begin
         @(posedge clk); #1;
         if (ov[2] && !prev) begin
            rise[nr] = c;
            nr++;
         end
         prev = ov[2];
      end
      iv[2] = 1'b0;
      chk("b2b results", 32'(nr), 32'd3);
      if (nr == 3) begin
         chk("b2b period 1", 32'(rise[1] - rise[0]), 32'd18);
         chk("b2b period 2", 32'(rise[2] - rise[1]), 32'd18);
      end
      chk("b2b bcd", 32'(bcd2), 32'h12345);
      repeat (20) @(posedge clk);
      #1;

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
